// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, then a final
// cycle that presents the product with fin high.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (go) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  // Counter exhausted: the accumulator holds the full product this cycle.
  assign fin     = busy && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with A/B operand registers, single-cycle logic/arith ops and
// a multi-cycle multiply, behind a start/busy/done handshake.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               sel_b,
  input  logic [WIDTH-1:0]   din,
  input  logic [2:0]         op,
  input  logic [SHIFT_W-1:0] shamt,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b
);

  state_e state, state_nxt;
  op_e    op_q;

  logic               mul_go, mul_busy, mul_fin;
  logic [2*WIDTH-1:0] mul_prod;
  logic               wr_alu, wr_mul;

  logic [WIDTH-1:0]   alu_y;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;

  assign op_q = op_e'(op);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .go      (mul_go),
    .a       (reg_a),
    .b       (reg_b),
    .busy    (mul_busy),
    .fin     (mul_fin),
    .product (mul_prod)
  );

  assign busy = mul_busy;

  // Shifts run one bit wider so the extra bit catches the last bit shifted out.
  assign add_w = {1'b0, reg_a} + {1'b0, reg_b};
  assign sub_w = {1'b0, reg_a} - {1'b0, reg_b};
  assign shl_w = {1'b0, reg_a} << shamt;
  assign shr_w = {reg_a, 1'b0} >> shamt;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_y = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (alu_y[WIDTH-1] != reg_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (alu_y[WIDTH-1] != reg_a[WIDTH-1]);
      end
      OP_AND: alu_y = reg_a & reg_b;
      OP_OR:  alu_y = reg_a | reg_b;
      OP_XOR: alu_y = reg_a ^ reg_b;
      OP_SHL: begin
        alu_y = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_y = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mul_go    = 1'b0;
    wr_alu    = 1'b0;
    wr_mul    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_q == OP_MUL) begin
            mul_go    = 1'b1;
            state_nxt = S_MUL;
          end else begin
            wr_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_fin) begin
          wr_mul    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      reg_a    <= '0;
      reg_b    <= '0;
      y        <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= wr_alu | wr_mul;
      if (load) begin
        if (sel_b) reg_b <= din;
        else       reg_a <= din;
      end
      if (wr_alu) begin
        y        <= alu_y;
        zero     <= (alu_y == '0);
        carry    <= alu_c;
        overflow <= alu_v;
      end else if (wr_mul) begin
        y        <= mul_prod[WIDTH-1:0];
        zero     <= (mul_prod[WIDTH-1:0] == '0);
        carry    <= |mul_prod[2*WIDTH-1:WIDTH];
        overflow <= |mul_prod[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=8.
module tb_alu_seq_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load, sel_b, start;
  logic [W-1:0] din;
  logic [2:0]   op;
  logic [2:0]   shamt;
  logic         busy, done, zero, carry, overflow;
  logic [W-1:0] y, reg_a, reg_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .sel_b(sel_b), .din(din), .op(op),
    .shamt(shamt), .start(start), .busy(busy), .done(done), .y(y),
    .zero(zero), .carry(carry), .overflow(overflow), .reg_a(reg_a), .reg_b(reg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic b, input logic [W-1:0] v);
    load = 1'b1; sel_b = b; din = v;
    tick();
    load = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [2:0] o, input logic [2:0] sh,
                      input logic [W-1:0] ey, input logic ec, input logic ev);
    op = o; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_zero"}, zero, (ey == '0));
    chk({tag, "_carry"}, carry, ec);
    chk({tag, "_ovf"}, overflow, ev);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_y_hold"}, y, ey);
  endtask

  // Starts a MUL and waits for done; optionally injects a start plus a B load
  // while the multiply is in flight.
  task automatic run_mul(input string tag, input logic inject,
                         output int n, output int bcnt);
    op = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; bcnt = 0;
    while (!done && n < 30) begin
      if (busy) bcnt++;
      if (inject && n == 3) begin
        start = 1'b1; op = 3'd0; load = 1'b1; sel_b = 1'b1; din = 8'h02;
      end
      tick();
      start = 1'b0; load = 1'b0; op = 3'd7;
      n++;
    end
    chk({tag, "_timeout"}, (n < 30), 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    int n, bcnt;
    bit saw_done;
    rst = 1'b1; load = 1'b0; sel_b = 1'b0; start = 1'b0;
    din = '0; op = '0; shamt = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_y", y, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {zero, carry, overflow}, 3'b000);
    chk("rst_regs", {reg_a, reg_b}, 16'h0000);

    ld(1'b0, 8'hFF); ld(1'b1, 8'h01);
    chk("load_regs", {reg_a, reg_b}, 16'hFF01);
    run1("add_wrap", 3'd0, 3'd0, 8'h00, 1'b1, 1'b0);

    ld(1'b0, 8'h7F);
    run1("add_ovf", 3'd0, 3'd0, 8'h80, 1'b0, 1'b1);

    ld(1'b0, 8'h03); ld(1'b1, 8'h05);
    run1("sub_borrow", 3'd1, 3'd0, 8'hFE, 1'b1, 1'b0);

    ld(1'b0, 8'h80); ld(1'b1, 8'h01);
    run1("sub_ovf", 3'd1, 3'd0, 8'h7F, 1'b0, 1'b1);

    ld(1'b0, 8'hF0); ld(1'b1, 8'hFF);
    run1("xor", 3'd4, 3'd0, 8'h0F, 1'b0, 1'b0);
    run1("and", 3'd2, 3'd0, 8'hF0, 1'b0, 1'b0);
    run1("or", 3'd3, 3'd0, 8'hFF, 1'b0, 1'b0);

    ld(1'b0, 8'h81);
    run1("shl1", 3'd5, 3'd1, 8'h02, 1'b1, 1'b0);
    run1("shl0", 3'd5, 3'd0, 8'h81, 1'b0, 1'b0);
    ld(1'b0, 8'h0C);
    run1("shr3", 3'd6, 3'd3, 8'h01, 1'b1, 1'b0);
    run1("shr4", 3'd6, 3'd4, 8'h00, 1'b1, 1'b0);

    // start in the same cycle as a load uses the old A (0x0C + 0xFF)
    op = 3'd0; start = 1'b1; load = 1'b1; sel_b = 1'b0; din = 8'h01;
    tick();
    start = 1'b0; load = 1'b0;
    chk("start_load_y", y, 8'h0B);
    chk("start_load_a", reg_a, 8'h01);

    ld(1'b0, 8'h10); ld(1'b1, 8'h10);
    run_mul("mul_100", 1'b1, n, bcnt);
    chk("mul_100_lat", n, 9);
    chk("mul_100_busy_cycles", bcnt, 9);
    chk("mul_100_y", y, 8'h00);
    chk("mul_100_flags", {zero, carry, overflow}, 3'b111);
    chk("mul_100_regb", reg_b, 8'h02);
    tick();
    chk("mul_100_pulse", done, 1'b0);

    ld(1'b0, 8'h0D); ld(1'b1, 8'h0B);
    run_mul("mul_8f", 1'b0, n, bcnt);
    chk("mul_8f_lat", n, 9);
    chk("mul_8f_y", y, 8'h8F);
    chk("mul_8f_flags", {zero, carry, overflow}, 3'b000);

    ld(1'b0, 8'h05); ld(1'b1, 8'h03);
    op = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mul_abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_y", y, 8'h00);
    chk("abort_flags", {zero, carry, overflow}, 3'b000);
    chk("abort_regs", {reg_a, reg_b}, 16'h0000);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised N-bit sequential ALU with a built-in operand register file, loaded A then B over one shared data bus.
- Supports single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) and a multi-cycle unsigned shift-add multiply.
- Uses a start/busy/done handshake; result and flags are registered.
- Feeds the flag display and output pins in the top-level wrapper.

Parameters:
- WIDTH, 8, operand/result width; power of two, ≥4.
- SHIFT_W, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  when high, din is written to reg_a (sel_b=0) or reg_b (sel_b=1)
- sel_b  in  1  operand select for load
- din  in  WIDTH  operand data
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- shamt  in  SHIFT_W  shift amount for SHL/SHR
- start  in  1  request an operation on the current reg_a/reg_b
- busy  out  1  high while MUL is iterating
- done  out  1  one-cycle pulse when y/flags update
- y  out  WIDTH  registered result
- zero  out  1  y == 0
- carry  out  1  carry/borrow/shift-out/mul-high flag
- overflow  out  1  signed overflow (MUL: unsigned overflow)
- reg_a  out  WIDTH  current operand A register
- reg_b  out  WIDTH  current operand B register

Behaviour:
- Reset: on any edge with rst=1, all outputs and registers go to 0 and the FSM goes to IDLE. This applies mid-MUL: the operation is aborted and no done is issued.
- Operand load: works in any state.
  - reg_a/reg_b update at the edge where load=1.
  - In-flight MUL is unaffected because operands are copied into working registers at start.
- start with load in the same cycle: start uses the pre-load reg_a/reg_b values.
- FSM states: IDLE, MUL.
  - IDLE with start and op≠MUL: y/flags are written at that edge; done=1 for the next cycle; FSM stays in IDLE. Latency is 1.
  - IDLE with start and op=MUL: go to MUL at that edge.
    - The edge copies operands, clears the accumulator, loads counter=WIDTH, and sets busy=1.
    - Each MUL cycle: if multiplier LSB=1, add multiplicand to the 2·WIDTH accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter.
    - At the edge where the counter reaches 0: write y/flags, set done=1, clear busy, return to IDLE.
    - done appears WIDTH+1 edges after the start edge. busy is high for WIDTH+1 cycles.
  - start while busy: ignored. No queueing; no error.
- y and flags hold between done pulses; done is high for exactly one cycle.
- Flag rules (results modulo 2^WIDTH):
  - ADD: carry = carry-out. overflow = operands have the same sign and the result sign differs.
  - SUB (A−B): carry = borrow (A<B unsigned). overflow = operand signs differ and the result sign differs from A.
  - AND/OR/XOR: carry=0, overflow=0.
  - SHL/SHR (logical, zero fill): carry = last bit shifted out; 0 when shamt=0. overflow=0.
  - MUL (unsigned): y = low WIDTH bits. carry = overflow = (high WIDTH bits ≠ 0).
  - All ops: zero = (y==0).

Decomposition:
- Package alu_seq_pkg: op_e enum (OP_ADD..OP_MUL, 3-bit) and state_e enum (S_IDLE, S_MUL).
- Sub-module alu_seq_mul: shift-add iterator.
  - Ports: clk, rst, go, a, b, busy, fin, product[2·WIDTH].
  - Instantiated once; the top holds operand registers, single-cycle datapath, flag logic and the result register.

Test Plan:
- WIDTH=8; load A=0xFF, B=0x01; ADD start → next cycle done=1, y=0x00, zero=1, carry=1, overflow=0.
- A=0x7F, B=0x01 ADD → y=0x80, overflow=1, carry=0. Then SUB with A=0x03, B=0x05 → y=0xFE, carry=1, overflow=0.
- A=0x81, SHL shamt=1 → y=0x02, carry=1. Then SHR shamt=3 on A=0x0C → y=0x01, carry=1.
- A=0x10, B=0x10 MUL → busy high 9 cycles, done on cycle 9 after start, y=0x00, zero=1, carry=1, overflow=1. A second start and a load B=0x02 issued mid-MUL → start ignored, reg_b=0x02, product unchanged.
- MUL 0x0D×0x0B → y=0x8F, carry=0, overflow=0.
- Assert rst for one cycle at cycle 4 of a MUL → busy=0, y=0, flags=0, reg_a=reg_b=0, and no done pulse follows.
